// File: rtl/enha_pkg.sv
// Shared definitions for the backlight enhancement path: mode encodings and
// the block-versus-mean rate threshold used by enhancement engines.
package enha_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_FIX    = 2'd1;
  localparam logic [1:0] MODE_ADAPT  = 2'd2;
  localparam logic [1:0] MODE_SMOOTH = 2'd3;

  // Darker blocks relative to the frame mean earn a larger rate (0..3).
  function automatic logic [1:0] rate_threshold(input logic [31:0] blk, input logic [31:0] mean);
    logic [1:0] rate;
    if (blk >= mean) begin
      rate = 2'd0;
    end else if (blk >= (mean >> 1)) begin
      rate = 2'd1;
    end else if (blk >= (mean >> 2)) begin
      rate = 2'd2;
    end else begin
      rate = 2'd3;
    end
    return rate;
  endfunction

endpackage

// File: rtl/enha_fifo.sv
// Synchronous FIFO with full/empty flags and a synchronous flush; a pop of
// a full FIFO frees room for a write in the same cycle.
module enha_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             wr_en_s;
  logic             rd_en_s;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en_s = pop_i && !empty_o;
  assign wr_en_s = push_i && (!full_o || rd_en_s);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Storage array, no reset needed since the pointers qualify every read.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  // Read/write pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else if (flush_i) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      if (wr_en_s) wr_ptr_q <= wr_ptr_q + (AW+1)'(1'b1);
      if (rd_en_s) rd_ptr_q <= rd_ptr_q + (AW+1)'(1'b1);
    end
  end

endmodule

// File: rtl/enha_block_engine.sv
// Per-block enhancement engine: buffers block averages with their line sums,
// derives a rate against the frame mean and emits saturated enhanced values.
module enha_block_engine
  import enha_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int SUM_W      = 14,
  parameter int RATE_W     = 2,
  parameter int GAIN_SHIFT = 2,
  parameter int BLK_SHIFT  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 7
) (
  input  logic              iODCK,
  input  logic              iRST,
  input  logic              iV_Duty,
  input  logic [CNT_W-1:0]  iV_Block_Duty_Count,
  input  logic              iWEA,
  input  logic [DATA_W-1:0] iBlockData,
  input  logic [SUM_W-1:0]  iLineSum,
  input  logic [1:0]        iMode,
  input  logic [RATE_W-1:0] iFixRate,
  input  logic              iReady,
  output logic [DATA_W-1:0] oBlockData_En,
  output logic [RATE_W-1:0] oEnhaRate,
  output logic              oValid,
  output logic              oFrameDone,
  output logic              oOvf
);

  localparam int ENTRY_W = DATA_W + SUM_W;
  localparam int PROD_W  = DATA_W + RATE_W;
  localparam int EXT_W   = DATA_W + RATE_W + 1;
  localparam logic [RATE_W-1:0] RATE_MAX = {RATE_W{1'b1}};
  localparam logic [EXT_W-1:0]  SAT_MAX  = EXT_W'({DATA_W{1'b1}});

  logic               push_s, pop_s, full_s, empty_s, adv_s, hs_s, drop_s;
  logic [ENTRY_W-1:0] fifo_rdata_s;
  logic [DATA_W-1:0]  fifo_blk_s;
  logic [SUM_W-1:0]   fifo_sum_s;
  logic [1:0]         t_raw_s;
  logic [RATE_W-1:0]  target_s, smooth_s, rate_n_s;
  logic [PROD_W-1:0]  prod_s, gain_s;
  logic [EXT_W-1:0]   sum_s;
  logic [DATA_W-1:0]  sat_s;
  logic [CNT_W-1:0]   cnt_d;
  logic               frame_done_d;

  logic               s1_valid_q, s2_valid_q, out_valid_q;
  logic [DATA_W-1:0]  s1_blk_q, s2_blk_q, out_data_q;
  logic [SUM_W-1:0]   s1_mean_q;
  logic [RATE_W-1:0]  s2_rate_q, out_rate_q, prev_n_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               frame_done_q, ovf_q;

  assign adv_s  = !out_valid_q || iReady;
  assign hs_s   = out_valid_q && iReady;
  assign push_s = iV_Duty && iWEA;
  // While downstream refuses, keep at most one block in flight so the FIFO does the buffering.
  assign pop_s  = adv_s && !empty_s && (iReady || !(s1_valid_q || s2_valid_q || out_valid_q));
  assign drop_s = push_s && full_s && !pop_s;
  assign fifo_blk_s = fifo_rdata_s[ENTRY_W-1:SUM_W];
  assign fifo_sum_s = fifo_rdata_s[SUM_W-1:0];

  enha_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (iODCK),
    .rst_ni  (iRST),
    .flush_i (!iV_Duty),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i ({iBlockData, iLineSum}),
    .rdata_o (fifo_rdata_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Rate selection for the block leaving S1.
  always_comb begin
    t_raw_s  = rate_threshold(32'(s1_blk_q), 32'(s1_mean_q));
    target_s = (32'(t_raw_s) > 32'(RATE_MAX)) ? RATE_MAX : RATE_W'(t_raw_s);
    if (prev_n_q < target_s) begin
      smooth_s = prev_n_q + RATE_W'(1'b1);
    end else if (prev_n_q > target_s) begin
      smooth_s = prev_n_q - RATE_W'(1'b1);
    end else begin
      smooth_s = prev_n_q;
    end
    case (iMode)
      MODE_BYPASS: rate_n_s = {RATE_W{1'b0}};
      MODE_FIX:    rate_n_s = iFixRate;
      MODE_ADAPT:  rate_n_s = target_s;
      MODE_SMOOTH: rate_n_s = smooth_s;
      default:     rate_n_s = {RATE_W{1'b0}};
    endcase
  end

  // Gain and saturation for the block in S2.
  always_comb begin
    prod_s = PROD_W'(s2_blk_q) * PROD_W'(s2_rate_q);
    gain_s = prod_s >> GAIN_SHIFT;
    sum_s  = EXT_W'(s2_blk_q) + EXT_W'(gain_s);
    if (sum_s > SAT_MAX) begin
      sat_s = {DATA_W{1'b1}};
    end else begin
      sat_s = sum_s[DATA_W-1:0];
    end
  end

  // Frame block counter; a zero block count never completes a frame.
  always_comb begin
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    if (hs_s) begin
      if ((iV_Block_Duty_Count != {CNT_W{1'b0}}) &&
          (cnt_q == iV_Block_Duty_Count - CNT_W'(1'b1))) begin
        cnt_d        = {CNT_W{1'b0}};
        frame_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1'b1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline, counter and overflow state; blanking clears everything but the data registers.
  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      s1_blk_q     <= {DATA_W{1'b0}};
      s1_mean_q    <= {SUM_W{1'b0}};
      s2_blk_q     <= {DATA_W{1'b0}};
      s2_rate_q    <= {RATE_W{1'b0}};
      out_data_q   <= {DATA_W{1'b0}};
      out_rate_q   <= {RATE_W{1'b0}};
      prev_n_q     <= {RATE_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else if (!iV_Duty) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      prev_n_q     <= {RATE_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      ovf_q        <= ovf_q || drop_s;
      if (adv_s) begin
        s1_valid_q  <= pop_s;
        s2_valid_q  <= s1_valid_q;
        out_valid_q <= s2_valid_q;
        if (pop_s) begin
          s1_blk_q  <= fifo_blk_s;
          s1_mean_q <= fifo_sum_s >> BLK_SHIFT;
        end
        if (s1_valid_q) begin
          s2_blk_q  <= s1_blk_q;
          s2_rate_q <= rate_n_s;
          prev_n_q  <= rate_n_s;
        end
        if (s2_valid_q) begin
          out_data_q <= sat_s;
          out_rate_q <= s2_rate_q;
        end
      end
    end
  end

  assign oBlockData_En = out_data_q;
  assign oEnhaRate     = out_rate_q;
  assign oValid        = out_valid_q;
  assign oFrameDone    = frame_done_q;
  assign oOvf          = ovf_q;

endmodule
